// File: rtl/rr_arbiter_4_pkg.sv
// rr_arbiter_4_pkg
// Shared types and constants for the four-requester round-robin arbiter.
//   NUM_REQ  : number of requesters sharing the resource
//   IDX_W    : width of a requester index
//   state_t  : arbiter FSM encoding (IDLE = no owner, GRANT = owner active)
//   dbg_t    : internal state exposed to observers (FSM state, priority pointer)
package rr_arbiter_4_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    state_t             state;
    logic [IDX_W-1:0]   ptr;
  } dbg_t;

endpackage

// File: rtl/rr_arbiter_4_if.sv
// rr_arbiter_4_if
// Request/grant bundle between the requesters and the arbiter.
//   req       : requester -> arbiter, req[i] high while requester i wants the resource
//   gnt       : arbiter -> requesters, one-hot grant (all zero when no owner)
//   gnt_idx   : arbiter -> requesters, index of the current owner
//   gnt_valid : arbiter -> requesters, high while a grant is active
//   preempt   : arbiter -> requesters, one-cycle pulse when a grant is revoked by timeout
//   dbg       : arbiter -> observers, FSM state and priority pointer
//
// Handshake: a requester raises req[i] and keeps it high for as long as it wants
// the resource. The grant appears one cycle after req[i] is sampled high and is
// held while req[i] stays high (up to the hold limit). Dropping req[i] releases
// the resource at the next rising edge. gnt never has more than one bit set.
interface rr_arbiter_4_if;
  import rr_arbiter_4_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_valid;
  logic               preempt;
  dbg_t               dbg;

  modport master (
    output req,
    input  gnt, gnt_idx, gnt_valid, preempt, dbg
  );

  modport slave (
    input  req,
    output gnt, gnt_idx, gnt_valid, preempt, dbg
  );

endinterface

// File: rtl/rr_arbiter_4_dec.sv
// rr_arbiter_4_dec
// 2-to-4 decoder with enable. Expands the registered owner index into the
// one-hot grant bus; the enable forces all outputs low when no grant is active.
//   a : index to decode
//   e : enable (grant valid)
//   d : one-hot output, all zero when e is low
module rr_arbiter_4_dec
  import rr_arbiter_4_pkg::*;
(
  input  logic [IDX_W-1:0]   a,
  input  logic               e,
  output logic [NUM_REQ-1:0] d
);

  always_comb begin
    d = '0;
    if (e) begin
      d[a] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4
// Four-requester round-robin arbiter with grant hold, release detection and a
// forced-rotation timeout. The owner is held as a registered index plus valid
// flag; the one-hot grant bus is a decode of those registers, so there is no
// combinational path from req to gnt and gnt can never show two bits set.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : request/grant bundle (slave side)
// Parameters:
//   HOLD_MAX : cycles one grant may be held before forced rotation (0 = no timeout)
//   CNT_W    : hold counter width, 2**CNT_W >= HOLD_MAX
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic          clk,
  input  logic          rst,
  rr_arbiter_4_if.slave bus
);

  // Counter value at which the grant has been visible for HOLD_MAX cycles.
  // With the timeout disabled the counter simply saturates at all ones.
  localparam logic [CNT_W-1:0] HOLD_LAST =
    (HOLD_MAX == 0) ? {CNT_W{1'b1}} : CNT_W'(HOLD_MAX - 1);

  // Registered state
  state_t             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   gnt_idx_q;
  logic               gnt_valid_q;
  logic [CNT_W-1:0]   hold_cnt_q;
  logic               preempt_q;

  // Next-state values
  state_t             state_n;
  logic [IDX_W-1:0]   ptr_n;
  logic [IDX_W-1:0]   gnt_idx_n;
  logic               gnt_valid_n;
  logic [CNT_W-1:0]   hold_cnt_n;
  logic               preempt_n;

  // Selection helpers
  logic [IDX_W-1:0]   owner_nxt;
  logic [IDX_W-1:0]   pick_ptr;
  logic [IDX_W-1:0]   pick_nxt;
  logic               any_req;
  logic               release_c;
  logic               timeout_c;
  logic [NUM_REQ-1:0] gnt_w;

  // First requester at or after start, scanning upward with wrap. Scanning
  // from the far end and overwriting leaves the nearest hit. If nothing is
  // requesting the result is start, which callers ignore via any_req.
  function automatic logic [IDX_W-1:0] pick(
    input logic [NUM_REQ-1:0] r,
    input logic [IDX_W-1:0]   start
  );
    logic [IDX_W-1:0] cand;
    pick = start;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = start + IDX_W'(k);
      if (r[cand]) begin
        pick = cand;
      end
    end
  endfunction

  // pick() evaluated from the priority pointer (fresh grant out of IDLE) and
  // from the slot after the current owner (hand-off). On a timeout with only
  // the owner requesting, the hand-off scan wraps back to the owner.
  always_comb begin
    owner_nxt = gnt_idx_q + IDX_W'(1);
    any_req   = |bus.req;
    pick_ptr  = pick(bus.req, ptr_q);
    pick_nxt  = pick(bus.req, owner_nxt);
  end

  // Release wins over timeout: a timeout needs the owner still requesting,
  // so the two conditions can never both be true.
  always_comb begin
    release_c = ~bus.req[gnt_idx_q];
    timeout_c = (HOLD_MAX != 0) && (hold_cnt_q == HOLD_LAST) && bus.req[gnt_idx_q];
  end

  // Next-state / output logic
  always_comb begin
    state_n     = state_q;
    ptr_n       = ptr_q;
    gnt_idx_n   = gnt_idx_q;
    gnt_valid_n = gnt_valid_q;
    hold_cnt_n  = hold_cnt_q;
    preempt_n   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_idx_n   = pick_ptr;
          gnt_valid_n = 1'b1;
          hold_cnt_n  = '0;
          state_n     = GRANT;
        end
      end

      GRANT: begin
        if (release_c || timeout_c) begin
          // Rotation point moves past the outgoing owner in either case.
          ptr_n     = owner_nxt;
          preempt_n = timeout_c && !release_c;
          if (any_req) begin
            // Direct hand-off: the index register switches in one edge, so
            // the decoded grant moves without an idle or overlap cycle.
            gnt_idx_n   = pick_nxt;
            gnt_valid_n = 1'b1;
            hold_cnt_n  = '0;
            state_n     = GRANT;
          end else begin
            gnt_valid_n = 1'b0;
            state_n     = IDLE;
          end
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_n = hold_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_n     = IDLE;
        gnt_valid_n = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      hold_cnt_q  <= '0;
      preempt_q   <= 1'b0;
    end else begin
      state_q     <= state_n;
      ptr_q       <= ptr_n;
      gnt_idx_q   <= gnt_idx_n;
      gnt_valid_q <= gnt_valid_n;
      hold_cnt_q  <= hold_cnt_n;
      preempt_q   <= preempt_n;
    end
  end

  rr_arbiter_4_dec u_dec (
    .a (gnt_idx_q),
    .e (gnt_valid_q),
    .d (gnt_w)
  );

  assign bus.gnt       = gnt_w;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.preempt   = preempt_q;
  assign bus.dbg       = '{state: state_q, ptr: ptr_q};

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb_rr_arbiter_4
// Self-checking bench for rr_arbiter_4 (HOLD_MAX = 8). A cycle-level reference
// model, written directly from the arbitration rules, predicts every output
// after each rising edge; directed sequences cover the key scenarios and a
// randomized phase covers the rest.
module tb_rr_arbiter_4;
  import rr_arbiter_4_pkg::*;

  localparam int HOLD_MAX = 8;
  localparam int VEC_W    = 11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_arbiter_4_if bus ();

  rr_arbiter_4 #(
    .HOLD_MAX (HOLD_MAX),
    .CNT_W    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard ----------------
  logic [VEC_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // owner / valid / ptr describe who holds the resource; cycles counts how
  // many cycles the current grant has been visible (1 on the first cycle).
  int m_owner  = 0;
  bit m_valid  = 0;
  int m_ptr    = 0;
  int m_cycles = 0;
  bit m_pre    = 0;

  function automatic int m_pick(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return start;
  endfunction

  task automatic model_step(input logic [3:0] r, input logic rs);
    bit rel;
    bit tmo;
    if (rs) begin
      m_owner = 0; m_valid = 0; m_ptr = 0; m_cycles = 0; m_pre = 0;
    end else if (!m_valid) begin
      m_pre = 0;
      if (r != 4'b0000) begin
        m_owner = m_pick(r, m_ptr); m_valid = 1; m_cycles = 1;
      end
    end else begin
      rel = (r[m_owner] == 1'b0);
      tmo = (HOLD_MAX != 0) && (m_cycles >= HOLD_MAX) && !rel;
      m_pre = tmo;
      if (rel || tmo) begin
        m_ptr = (m_owner + 1) % 4;
        if (r != 4'b0000) begin
          m_owner = m_pick(r, m_ptr); m_cycles = 1;
        end else begin
          m_valid = 0;
        end
      end else begin
        m_cycles++;
      end
    end
  endtask

  function automatic logic [VEC_W-1:0] model_vec();
    logic [3:0] g;
    g = m_valid ? 4'(1 << m_owner) : 4'b0000;
    return {g, 2'(m_owner), m_valid, m_pre, m_valid, 2'(m_ptr)};
  endfunction

  // ---------------- checks ----------------
  task automatic check_out(input string tag);
    logic [VEC_W-1:0] exp_v;
    logic [VEC_W-1:0] obs_v;
    exp_v = exp_q.pop_front();
    obs_v = {bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.preempt,
             bus.dbg.state, bus.dbg.ptr};
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s: observed gnt/idx/vld/pre/st/ptr=%b expected %b", tag, obs_v, exp_v);
    end
    checks++;
    assert ($onehot0(bus.gnt) === 1'b1) else begin
      errors++;
      $error("FAIL %s_onehot: observed gnt=%b expected at most one bit", tag, bus.gnt);
    end
  endtask

  task automatic check_val(input string tag, input int obs, input int exp_val);
    checks++;
    assert (obs === exp_val) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_val);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [3:0] r, input logic rs, input string tag);
    @(negedge clk);
    rst     = rs;
    bus.req = r;
    @(posedge clk);
    model_step(r, rs);
    exp_q.push_back(model_vec());
    #1;
    check_out(tag);
  endtask

  task automatic do_reset();
    step(4'b0000, 1'b1, "reset");
    step(4'b0000, 1'b1, "reset");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int order[5];
    int exp_order[5];
    int pulses;
    int bad;
    logic [3:0] r;
    int run;

    rst     = 1'b1;
    bus.req = 4'b0000;
    exp_order = '{0, 1, 2, 3, 0};

    // Reset and quiet bus
    do_reset();
    for (int i = 0; i < 5; i++) step(4'b0000, 1'b0, "idle");

    // Single requester, release, pointer moves past it
    step(4'b0100, 1'b0, "single_grant");
    check_val("single_idx", int'(bus.gnt_idx), 2);
    step(4'b0000, 1'b0, "single_release");
    check_val("single_ptr", int'(bus.dbg.ptr), 3);

    // Full rotation with back-to-back hand-offs
    do_reset();
    step(4'b1111, 1'b0, "rot_grant");
    order[0] = int'(bus.gnt_idx);
    for (int n = 1; n < 5; n++) begin
      step(4'b1111, 1'b0, "rot_hold");
      step(4'b1111 & ~(4'b0001 << m_owner), 1'b0, "rot_handoff");
      order[n] = int'(bus.gnt_idx);
    end
    for (int n = 0; n < 5; n++) check_val("rot_order", order[n], exp_order[n]);

    // Two constant requesters: forced rotation every HOLD_MAX cycles
    do_reset();
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step(4'b0011, 1'b0, "timeout_pair");
      if (bus.preempt) pulses++;
    end
    check_val("timeout_pair_pulses", pulses, 4);

    // Lone requester: re-granted to itself with a preempt pulse each time
    do_reset();
    pulses = 0;
    bad    = 0;
    for (int i = 0; i < 30; i++) begin
      step(4'b0010, 1'b0, "timeout_solo");
      if (bus.preempt) pulses++;
      if (bus.gnt !== 4'b0010) bad++;
    end
    check_val("timeout_solo_pulses", pulses, 3);
    check_val("timeout_solo_gnt_drops", bad, 0);

    // Reset in the middle of a grant
    do_reset();
    step(4'b1000, 1'b0, "midrst_grant");
    check_val("midrst_gnt_before", int'(bus.gnt), 8);
    step(4'b1111, 1'b1, "midrst_assert");
    check_val("midrst_gnt_during", int'(bus.gnt), 0);
    step(4'b1111, 1'b0, "midrst_regrant");
    check_val("midrst_gnt_after", int'(bus.gnt), 1);

    // Randomized: request patterns held for random run lengths, rare resets
    do_reset();
    for (int i = 0; i < 60; i++) begin
      r   = 4'($urandom_range(0, 15));
      run = $urandom_range(1, 20);
      for (int j = 0; j < run; j++) begin
        if ($urandom_range(0, 3) == 0) r = r ^ 4'(1 << $urandom_range(0, 3));
        step(r, ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0, "random");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
